reg_file_mp: RTL and testbench



---
 rtl/reg_file_pkg.sv | 33 +++
 rtl/rf_scoreboard.sv | 57 +++++
 rtl/reg_file_mp.sv | 102 ++++++++++
 tb/tb_reg_file_mp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_pkg : shared widths and helpers for the multi-port register file
// Revision     : 1.0
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DEF_WORD_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int NREGS              = 2**DEF_REG_ADDR_WIDTH;

  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;
  localparam int MAX_REGS   = 256;
  localparam int CNT_MAX_W  = 9;

  // Highest-index set bit wins, matching write-port priority.
  function automatic logic [PORT_IDX_W-1:0] win_port(input logic [MAX_PORTS-1:0] hits);
    win_port = '0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (hits[p]) win_port = PORT_IDX_W'(p);
    end
  endfunction

  function automatic logic [CNT_MAX_W-1:0] popcount(input logic [MAX_REGS-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_REGS; i++) begin
      popcount = popcount + CNT_MAX_W'(v[i]);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_scoreboard : per-register busy bits with reserve-over-release priority
// Revision      : 1.0
// ---------------------------------------------------------------------------
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_WR         = 2,
  parameter int ZERO_REG       = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rsv_en,
  input  logic [REG_ADDR_WIDTH-1:0]        rsv_addr,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  output logic [2**REG_ADDR_WIDTH-1:0]     busy_vec,
  output logic [REG_ADDR_WIDTH:0]          busy_cnt,
  output logic                             rsv_ok
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam int A        = REG_ADDR_WIDTH;
  localparam int CNT_W    = REG_ADDR_WIDTH + 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Clears applied first so a same-cycle reserve overrides them.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p]) busy_d[wr_addr[p*A +: A]] = 1'b0;
    end
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    cnt_d = CNT_W'(popcount(MAX_REGS'(busy_d)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
  assign rsv_ok   = ~busy_q[rsv_addr];

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_mp : multi-port register file with write bypass and busy scoreboard
// Revision    : 1.0
// ---------------------------------------------------------------------------
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 2,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*WORD_WIDTH-1:0]     rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*WORD_WIDTH-1:0]     wr_data,
  input  logic                             rsv_en,
  input  logic [REG_ADDR_WIDTH-1:0]        rsv_addr,
  output logic                             rsv_ok,
  output logic [2**REG_ADDR_WIDTH-1:0]     busy_vec,
  output logic [REG_ADDR_WIDTH:0]          busy_cnt
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam int W        = WORD_WIDTH;
  localparam int A        = REG_ADDR_WIDTH;

  logic [W-1:0]         regs_q [NUM_REGS];
  logic [W-1:0]         regs_d [NUM_REGS];
  logic [MAX_PORTS-1:0] reg_hit [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_hit[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        reg_hit[r][p] = wr_en[p] && (wr_addr[p*A +: A] == A'(r));
      end
      regs_d[r] = regs_q[r];
      if ((|reg_hit[r]) && !((ZERO_REG != 0) && (r == 0))) begin
        regs_d[r] = wr_data[int'(win_port(reg_hit[r]))*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [A-1:0]         ra;
    logic [MAX_PORTS-1:0] rhit;
    logic                 byp_hit;
    logic                 rsv_hit;

    assign ra = rd_addr[i*A +: A];

    always_comb begin
      rhit = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        rhit[p] = wr_en[p] && (wr_addr[p*A +: A] == ra);
      end
    end

    assign byp_hit = (BYPASS != 0) && (|rhit);
    assign rsv_hit = rsv_en && (rsv_addr == ra);

    // The zero-register rule takes precedence over any bypass.
    assign rd_data[i*W +: W] = ((ZERO_REG != 0) && (ra == '0)) ? '0 :
                               byp_hit ? wr_data[int'(win_port(rhit))*W +: W] :
                               regs_q[ra];
    assign rd_busy[i] = busy_vec[ra] & ~(byp_hit & ~rsv_hit);
  end

  rf_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_WR         (NUM_WR),
    .ZERO_REG       (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt),
    .rsv_ok   (rsv_ok)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_file_mp : directed and random checks of bypass and non-bypass builds
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  localparam int W   = 32;
  localparam int A   = 5;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NRD*A-1:0] rd_addr;
  logic [NWR-1:0]   wr_en;
  logic [NWR*A-1:0] wr_addr;
  logic [NWR*W-1:0] wr_data;
  logic             rsv_en;
  logic [A-1:0]     rsv_addr;

  logic [NRD*W-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]   rd_busy, rd_busy_nb;
  logic             rsv_ok, rsv_ok_nb;
  logic [NR-1:0]    busy_vec, busy_vec_nb;
  logic [A:0]       busy_cnt, busy_cnt_nb;

  always #5 clk = ~clk;

  reg_file_mp #(.WORD_WIDTH(W), .REG_ADDR_WIDTH(A), .NUM_RD(NRD), .NUM_WR(NWR),
                .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_vec(busy_vec), .busy_cnt(busy_cnt));

  reg_file_mp #(.WORD_WIDTH(W), .REG_ADDR_WIDTH(A), .NUM_RD(NRD), .NUM_WR(NWR),
                .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_nb), .busy_vec(busy_vec_nb), .busy_cnt(busy_cnt_nb));

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mem [NR];
  logic [NR-1:0] busy_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) mem[r] = '0;
    busy_m = '0;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
  endtask

  function automatic int count_busy();
    int c = 0;
    for (int r = 0; r < NR; r++) c += int'(busy_m[r]);
    return c;
  endfunction

  // Check all combinational outputs of both builds against the model.
  task automatic settle();
    #1;
    for (int i = 0; i < NRD; i++) begin
      logic [A-1:0] a;
      logic [W-1:0] d;
      logic         hit;
      logic         bb;
      a   = rd_addr[i*A +: A];
      d   = mem[a];
      hit = 1'b0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*A +: A] == a) begin
          hit = 1'b1;
          d   = wr_data[p*W +: W];
        end
      end
      if (a == 0) d = '0;
      bb = busy_m[a] && !(hit && !(rsv_en && rsv_addr == a));
      chk($sformatf("rd_data%0d(x%0d)", i, a), 64'(rd_data[i*W +: W]), 64'(d));
      chk($sformatf("nb_rd_data%0d(x%0d)", i, a), 64'(rd_data_nb[i*W +: W]), 64'(mem[a]));
      chk($sformatf("rd_busy%0d(x%0d)", i, a), 64'(rd_busy[i]), 64'(bb));
      chk($sformatf("nb_rd_busy%0d(x%0d)", i, a), 64'(rd_busy_nb[i]), 64'(busy_m[a]));
    end
    chk("rsv_ok", 64'(rsv_ok), 64'(!busy_m[rsv_addr]));
    chk("nb_rsv_ok", 64'(rsv_ok_nb), 64'(!busy_m[rsv_addr]));
  endtask

  // Advance one clock, apply the architectural update, check registered state.
  task automatic tick();
    @(posedge clk);
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) begin
        if (wr_addr[p*A +: A] != 0) mem[wr_addr[p*A +: A]] = wr_data[p*W +: W];
        busy_m[wr_addr[p*A +: A]] = 1'b0;
      end
    end
    if (rsv_en && rsv_addr != 0) busy_m[rsv_addr] = 1'b1;
    #1;
    chk("busy_vec", 64'(busy_vec), 64'(busy_m));
    chk("busy_cnt", 64'(busy_cnt), 64'(count_busy()));
    chk("nb_busy_vec", 64'(busy_vec_nb), 64'(busy_m));
    chk("nb_busy_cnt", 64'(busy_cnt_nb), 64'(count_busy()));
    @(negedge clk);
  endtask

  initial begin
    int cnt_before;
    idle();
    model_clear();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);
    chk("reset_busy_cnt", 64'(busy_cnt), 64'h0);
    chk("reset_rsv_ok", 64'(rsv_ok), 64'h1);
    reset = 1'b1;
    settle();

    // Reset test: write x21 and reserve x4, then async reset mid-cycle.
    wr_en = 2'b01; wr_addr[0 +: A] = 5'd21; wr_data[0 +: W] = 32'h69;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    settle(); tick();
    idle(); rd_addr[0 +: A] = 5'd21;
    settle();
    chk("pre_reset_x21", 64'(rd_data[0 +: W]), 64'h69);
    wr_en = 2'b10; wr_addr[A +: A] = 5'd21; wr_data[W +: W] = 32'h77;
    #1 reset = 1'b0;
    #1;
    model_clear();
    chk("reset_x21_now", 64'(rd_data_nb[0 +: W]), 64'h0);
    chk("reset_cnt_now", 64'(busy_cnt), 64'h0);
    chk("reset_vec_now", 64'(busy_vec), 64'h0);
    wr_en = '0;
    #1 reset = 1'b1;
    tick();

    // Dual write conflict on x5.
    idle();
    wr_en = 2'b11;
    wr_addr[0 +: A] = 5'd5; wr_data[0 +: W] = 32'h11;
    wr_addr[A +: A] = 5'd5; wr_data[W +: W] = 32'h22;
    rd_addr[0 +: A] = 5'd5;
    settle();
    chk("conflict_bypass", 64'(rd_data[0 +: W]), 64'h22);
    tick();
    idle(); rd_addr[A +: A] = 5'd5;
    settle();
    chk("conflict_stored", 64'(rd_data[W +: W]), 64'h22);

    // Writes and reserves to x0 are ignored.
    cnt_before = int'(busy_cnt);
    wr_en = 2'b01; wr_addr[0 +: A] = 5'd0; wr_data[0 +: W] = 32'hDEAD;
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = '0;
    settle();
    chk("x0_bypass_read", 64'(rd_data[0 +: W]), 64'h0);
    tick();
    chk("x0_busy", 64'(busy_vec[0]), 64'h0);
    chk("x0_cnt", 64'(busy_cnt), 64'(cnt_before));

    // Scoreboard lifecycle on x7.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd7;
    settle(); tick();
    idle(); rd_addr[0 +: A] = 5'd7; rsv_addr = 5'd7;
    settle();
    chk("x7_rd_busy", 64'(rd_busy[0]), 64'h1);
    chk("x7_cnt", 64'(busy_cnt), 64'h1);
    chk("x7_rsv_ok", 64'(rsv_ok), 64'h0);
    wr_en = 2'b01; wr_addr[0 +: A] = 5'd7; wr_data[0 +: W] = 32'h65;
    settle(); tick();
    chk("x7_cnt_clr", 64'(busy_cnt), 64'h0);
    idle(); rd_addr[0 +: A] = 5'd7;
    settle();
    chk("x7_data", 64'(rd_data_nb[0 +: W]), 64'h65);
    chk("x7_busy_clr", 64'(rd_busy[0]), 64'h0);

    // Reserve wins over a same-cycle write to x9.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd9;
    settle(); tick();
    cnt_before = int'(busy_cnt);
    wr_en = 2'b10; wr_addr[A +: A] = 5'd9; wr_data[W +: W] = 32'h6500;
    settle(); tick();
    chk("x9_busy", 64'(busy_vec[9]), 64'h1);
    chk("x9_cnt", 64'(busy_cnt), 64'(cnt_before));
    idle(); rd_addr[0 +: A] = 5'd9;
    settle();
    chk("x9_data", 64'(rd_data_nb[0 +: W]), 64'h6500);

    // Non-bypass build sees the old value until after the edge.
    idle();
    wr_en = 2'b01; wr_addr[0 +: A] = 5'd3; wr_data[0 +: W] = 32'h42;
    rd_addr[A +: A] = 5'd3;
    settle();
    chk("nb_x3_old", 64'(rd_data_nb[W +: W]), 64'h0);
    chk("byp_x3_new", 64'(rd_data[W +: W]), 64'h42);
    tick();
    wr_en = '0;
    settle();
    chk("nb_x3_next", 64'(rd_data_nb[W +: W]), 64'h42);

    // Random traffic, addresses biased low to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NWR; p++) begin
        wr_en[p] = ($urandom_range(0, 1) == 1);
        wr_addr[p*A +: A] = ($urandom_range(0, 3) == 0) ? A'($urandom_range(0, NR-1))
                                                        : A'($urandom_range(0, 7));
        wr_data[p*W +: W] = $urandom;
      end
      for (int i = 0; i < NRD; i++) rd_addr[i*A +: A] = A'($urandom_range(0, 9));
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = A'($urandom_range(0, 9));
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
